// File: rtl/des_pkg.sv
// Shared constants and types for the DES key-schedule engine.
// Permutation tables use 1-based DES bit numbering (bit 1 = MSB).
package des_pkg;

   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Bit n set: the rotation into round index n is by one position, else by two.
   localparam logic [15:0] SHIFT1_MASK = 16'h8103;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/des_pc2.sv
// PC-2 permutation: selects 48 of the 56 C/D bits to form a round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [1:56] cd,
   output logic [1:48] subkey
);

   always_comb begin
      subkey = '0;
      for (int i = 0; i < 48; i++) begin
         subkey[i+1] = cd[PC2[i]];
      end
   end

endmodule

// File: rtl/des_subkey_stream.sv
// DES key schedule: loads PC-1 of the key on start, then streams the 16
// round subkeys over a valid/ready handshake in encrypt or decrypt order.
//
// state | meaning
// IDLE  | waiting for start; no subkey presented
// RUN   | subkey for `round` presented, advances on each accepted handshake
// DONE  | one-cycle completion pulse after the 16th subkey is accepted
module des_subkey_stream
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:64] key,
   input  logic        des_mode,
   input  logic        abort,
   input  logic        sk_ready,
   output logic        sk_valid,
   output logic [1:48] subkey,
   output logic [3:0]  round,
   output logic        busy,
   output logic        done
);

   state_t      state;
   logic        mode;
   logic [1:56] cd_reg;
   logic [1:56] pc1_cd;
   logic [1:56] cd_load;
   logic [1:56] cd_next;
   logic [3:0]  round_next;
   logic        next_by2;

   function automatic logic [1:28] rot_left(input logic [1:28] h, input logic by2);
      return by2 ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
   endfunction

   function automatic logic [1:28] rot_right(input logic [1:28] h, input logic by2);
      return by2 ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
   endfunction

   always_comb begin
      pc1_cd = '0;
      for (int i = 0; i < 56; i++) begin
         pc1_cd[i+1] = key[PC1[i]];
      end
   end

   // Decrypt starts from the unrotated PC-1 state, which is exactly K16's C/D.
   always_comb begin
      if (des_mode == DEC) begin
         cd_load = pc1_cd;
      end else begin
         cd_load = {rot_left(pc1_cd[1:28],  !SHIFT1_MASK[0]),
                    rot_left(pc1_cd[29:56], !SHIFT1_MASK[0])};
      end
   end

   assign round_next = round + 4'd1;
   assign next_by2   = !SHIFT1_MASK[round_next];

   always_comb begin
      if (mode == DEC) begin
         cd_next = {rot_right(cd_reg[1:28], next_by2), rot_right(cd_reg[29:56], next_by2)};
      end else begin
         cd_next = {rot_left(cd_reg[1:28], next_by2), rot_left(cd_reg[29:56], next_by2)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode   <= ENC;
         cd_reg <= '0;
         round  <= '0;
      end else if (abort) begin
         state <= IDLE;
         round <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode   <= des_mode;
                  cd_reg <= cd_load;
                  round  <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (sk_ready) begin
                  if (round == 4'd15) begin
                     state <= DONE;
                  end else begin
                     round  <= round_next;
                     cd_reg <= cd_next;
                  end
               end
            end
            DONE: begin
               round <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sk_valid = (state == RUN);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   des_pc2 u_pc2 (
      .cd     (cd_reg),
      .subkey (subkey)
   );

endmodule

// File: tb/tb_des_subkey_stream.sv
// Directed bench for des_subkey_stream using the classic 133457799BBCDFF1
// key schedule as reference, with stall, abort, restart and reset sequences.
module tb_des_subkey_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:64] key_in;
   logic        des_mode;
   logic        abort;
   logic        sk_ready;
   logic        sk_valid;
   logic [1:48] subkey;
   logic [3:0]  round;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [47:0] gold [16];

   typedef struct {
      logic        mode;
      logic [63:0] key;
      logic        zero;
      int          stall;
      int          poke_at;
      int          abort_at;
      int          rst_at;
   } scen_t;

   scen_t scen [10];

   always #5 clk = ~clk;

   des_subkey_stream dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key      (key_in),
      .des_mode (des_mode),
      .abort    (abort),
      .sk_ready (sk_ready),
      .sk_valid (sk_valid),
      .subkey   (subkey),
      .round    (round),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_stream(input scen_t s);
      int   n = 0;
      int   cyc = 0;
      int   idx;
      logic rdy;
      logic poked = 1'b0;

      @(negedge clk);
      key_in   = s.key;
      des_mode = s.mode;
      start    = 1'b1;
      sk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;

      while (n < 16 && cyc < 400) begin
         idx = s.mode ? 15 - n : n;
         chk("sk_valid", sk_valid, 1);
         chk("busy", busy, 1);
         chk("done_low", done, 0);
         chk("round", round, n);
         chk("subkey", subkey, s.zero ? 48'h0 : gold[idx]);

         if (n == s.abort_at) begin
            abort    = 1'b1;
            sk_ready = 1'b1;
            @(negedge clk);
            abort    = 1'b0;
            sk_ready = 1'b0;
            chk("abort_valid", sk_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_round", round, 0);
            chk("abort_done", done, 0);
            repeat (3) begin
               @(negedge clk);
               chk("abort_no_done", done, 0);
               chk("abort_idle", sk_valid, 0);
            end
            return;
         end

         if (n == s.rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", sk_valid, 0);
            chk("rst_subkey", subkey, 0);
            chk("rst_round", round, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_release_valid", sk_valid, 0);
            chk("rst_release_busy", busy, 0);
            return;
         end

         rdy = (s.stall > 0) ? ($urandom_range(99) < s.stall) : 1'b1;
         sk_ready = rdy;
         if (n == s.poke_at && !poked) begin
            start    = 1'b1;
            key_in   = '0;
            des_mode = ~s.mode;
            poked    = 1'b1;
         end
         @(negedge clk);
         start    = 1'b0;
         key_in   = s.key;
         des_mode = s.mode;
         cyc++;
         if (rdy) n++;
      end

      chk("rounds_done", n, 16);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_valid", sk_valid, 0);
      if (s.stall == 0) chk("done_latency", cyc, 16);
      sk_ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_valid", sk_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      gold[0]  = 48'h1B02EFFC7072;
      gold[1]  = 48'h79AED9DBC9E5;
      gold[2]  = 48'h55FC8A42CF99;
      gold[3]  = 48'h72ADD6DB351D;
      gold[4]  = 48'h7CEC07EB53A8;
      gold[5]  = 48'h63A53E507B2F;
      gold[6]  = 48'hEC84B7F618BC;
      gold[7]  = 48'hF78A3AC13BFB;
      gold[8]  = 48'hE0DBEBEDE781;
      gold[9]  = 48'hB1F347BA464F;
      gold[10] = 48'h215FD3DED386;
      gold[11] = 48'h7571F59467E9;
      gold[12] = 48'h97C5D1FABA41;
      gold[13] = 48'h5F43B7F2E73A;
      gold[14] = 48'hBF918D3D3F0A;
      gold[15] = 48'hCB3D8B0E17F5;

      //              mode  key                    zero  stall poke abort rst
      scen[0] = '{1'b0, 64'h133457799BBCDFF1, 1'b0, 0,  -1, -1, -1};
      scen[1] = '{1'b1, 64'h133457799BBCDFF1, 1'b0, 0,  -1, -1, -1};
      scen[2] = '{1'b0, 64'h133457799BBCDFF1, 1'b0, 30, -1, -1, -1};
      scen[3] = '{1'b0, 64'h133457799BBCDFF1, 1'b0, 0,   7, -1, -1};
      scen[4] = '{1'b1, 64'h133457799BBCDFF1, 1'b0, 30, -1, -1, -1};
      scen[5] = '{1'b0, 64'h133457799BBCDFF1, 1'b0, 0,  -1,  5, -1};
      scen[6] = '{1'b0, 64'h0,                1'b1, 0,  -1, -1, -1};
      scen[7] = '{1'b1, 64'h0,                1'b1, 0,  -1, -1, -1};
      scen[8] = '{1'b0, 64'h133457799BBCDFF1, 1'b0, 0,  -1, -1, 10};
      scen[9] = '{1'b1, 64'h133457799BBCDFF1, 1'b0, 0,  -1, -1, -1};

      rst_n    = 1'b0;
      start    = 1'b0;
      key_in   = '0;
      des_mode = 1'b0;
      abort    = 1'b0;
      sk_ready = 1'b0;

      #3;
      chk("reset_valid", sk_valid, 0);
      chk("reset_subkey", subkey, 0);
      chk("reset_round", round, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // abort and start together in IDLE: start must be dropped
      key_in   = 64'h133457799BBCDFF1;
      start    = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      chk("abort_start_valid", sk_valid, 0);
      @(negedge clk);
      chk("abort_start_busy_later", busy, 0);

      for (int i = 0; i < 10; i++) begin
         run_stream(scen[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
